bulls_cows_judge: RTL and testbench
===================================

// Module: bulls_cows_judge
// PURPOSE
//  Game-logic stage directly upstream of the text-LCD driver. Holds the secret number,
//  collects a guess one keypad digit at a time, and scores it against the secret.
//  The strike/ball counts it publishes drive the LCD strike/ball inputs, so they are held stable between scorings.
// PARAMETERS
//  DIGITS     4   digits per secret/guess, range 1..8; a count of DIGITS must fit in 4 bits
//  MAX_TRIES  10  scored guesses allowed before the game ends without a win, range 1..15
// PORTS
//  clk          in   1          system clock, rising edge
//  rst          in   1          asynchronous, active-high reset
//  secret_load  in   1          1-cycle strobe: load secret_in and start a new game
//  secret_in    in   4*DIGITS   BCD secret; nibble i = digit position i (position 0 = first/leftmost)
//  key_valid    in   1          1-cycle strobe: key_code is valid
//  key_code     in   4          0-9 digit, 4'hA clear, 4'hB enter, 4'hC-4'hF ignored
//  strike       out  4          strikes of the last scored guess
//  ball         out  4          balls of the last scored guess
//  result_valid out  1          1-cycle pulse when strike/ball update
//  entry_count  out  4          digits of the current guess entered so far
//  tries        out  4          guesses scored in this game
//  win          out  1          last scored guess had strike==DIGITS; held until the next game
//  game_over    out  1          high in state DONE
//  err          out  1          1-cycle pulse on a rejected key or rejected secret
// BEHAVIOUR
//  Reset values:
//   - all outputs 0; state IDLE; guess and secret registers cleared
//  FSM states: IDLE, ENTRY, COMPARE, RESULT, DONE
//  Secret load (priority):
//   - secret_load beats key_valid in the same cycle and is accepted in any state, including mid-COMPARE.
//   - Valid secret: all nibbles <=9 and pairwise distinct. Then clear strike, ball, tries,
//     entry_count and win, and go to ENTRY next cycle.
//   - Invalid secret: err pulse, go to IDLE, secret register unchanged, game outputs cleared.
//  IDLE:
//   - key_valid ignored (no err).
//  ENTRY, digit key 0-9:
//   - With entry_count<DIGITS and the digit not already in the guess: store at position
//     entry_count, entry_count+1.
//   - Duplicate digit, or entry_count==DIGITS: key dropped, err pulse.
//  ENTRY, other keys:
//   - Clear (A): entry_count=0 and guess cleared; never errs.
//   - Enter (B) with entry_count==DIGITS: go to COMPARE with index j=0.
//   - Enter (B) with entry_count<DIGITS: err pulse, stay in ENTRY.
//   - Codes C-F: ignored, no err.
//  COMPARE:
//   - One guess digit per cycle; internal accumulators s and b are cleared on entry.
//   - Cycle j: if guess[j]==secret[j] then s+1; else if guess[j] equals any secret digit then b+1.
//   - After j=DIGITS-1, go to RESULT. Keys ignored.
//  RESULT (one cycle):
//   - strike<=s, ball<=b, result_valid=1, tries+1 (saturates at 15), entry_count<=0.
//   - Go to DONE if s==DIGITS (win<=1) or the new tries==MAX_TRIES; else to ENTRY.
//  Latency: accepted Enter to result_valid = DIGITS+1 cycles; strike/ball change only in RESULT.
//  DONE:
//   - game_over=1; keys ignored, no err; stays until secret_load.
//  Widths: strike+ball <= DIGITS always; both are unsigned 4 bit.
//  Reset mid-operation: immediate return to reset values; a partial guess is discarded.
// TESTING
//  T1: secret 1234, keys 1,2,4,3,B -> after 5 cycles result_valid, strike=2, ball=2, tries=1
//  T2: secret 1234, guess 1234 -> strike=4, ball=0, win=1, game_over=1; later keys ignored
//  T3: secret 5678, keys 1,1 -> second 1 gives err, entry_count=1; keys 2,B -> err, stays in ENTRY
//  T4: secret_in 16'h1123 -> err, state IDLE, digit keys ignored without err
//  T5: MAX_TRIES=2, two wrong guesses 9087 vs 1234 -> strike=0, ball=0, tries=2, game_over=1, win=0
//  T6: Enter then secret_load during COMPARE -> no result_valid; strike/ball=0; entry_count=0; ENTRY

Source files
------------

// File: rtl/bulls_cows_judge_if.sv
// ---------------------------------------------------------------------------
// bulls_cows_judge_if
//  Bundles the keypad/secret inputs and the scoring outputs of the
//  Bulls & Cows judge so the game stage and its neighbours share one port.
//
//  Signals (direction seen from the judge, i.e. the slave modport):
//   secret_load  in   1-cycle strobe: load secret_in and start a new game
//   secret_in    in   4*DIGITS BCD secret, nibble i = position i (0 = leftmost)
//   key_valid    in   1-cycle strobe: key_code is valid
//   key_code     in   0-9 digit, A clear, B enter, C-F ignored
//   strike       out  strikes of the last scored guess
//   ball         out  balls of the last scored guess
//   result_valid out  1-cycle pulse when strike/ball update
//   entry_count  out  digits of the current guess entered so far
//   tries        out  guesses scored in this game
//   win          out  last scored guess was all strikes; held until next game
//   game_over    out  game finished (win or out of tries)
//   err          out  1-cycle pulse on a rejected key or rejected secret
// ---------------------------------------------------------------------------
interface bulls_cows_judge_if #(
   parameter int DIGITS = 4
);
   logic                  secret_load;
   logic [4*DIGITS-1:0]   secret_in;
   logic                  key_valid;
   logic [3:0]            key_code;
   logic [3:0]            strike;
   logic [3:0]            ball;
   logic                  result_valid;
   logic [3:0]            entry_count;
   logic [3:0]            tries;
   logic                  win;
   logic                  game_over;
   logic                  err;

   // Driver side: keypad controller / host that owns the secret.
   modport master (
      output secret_load, secret_in, key_valid, key_code,
      input  strike, ball, result_valid, entry_count, tries, win, game_over, err
   );

   // Judge side.
   modport slave (
      input  secret_load, secret_in, key_valid, key_code,
      output strike, ball, result_valid, entry_count, tries, win, game_over, err
   );
endinterface

// File: rtl/bulls_cows_judge.sv
// ---------------------------------------------------------------------------
// bulls_cows_judge
//  Game-logic stage feeding the text-LCD driver. Holds the secret number,
//  collects a guess one keypad digit at a time and scores it against the
//  secret, one guess digit per clock. strike/ball are registers that only
//  change when a guess is scored (or a new game starts), so the LCD sees
//  stable values in between.
//
//  Parameters:
//   DIGITS     digits per secret/guess (1..8)
//   MAX_TRIES  scored guesses allowed before the game ends without a win (1..15)
//
//  Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   bulls_cows_judge_if.slave: keypad/secret inputs, score outputs
// ---------------------------------------------------------------------------
module bulls_cows_judge #(
   parameter int DIGITS    = 4,
   parameter int MAX_TRIES = 10
) (
   input logic               clk,
   input logic               rst,
   bulls_cows_judge_if.slave bus
);

   localparam logic [3:0] DIGITS_W  = 4'(DIGITS);
   localparam logic [3:0] MAX_W     = 4'(MAX_TRIES);
   localparam logic [3:0] LAST_IDX  = 4'(DIGITS - 1);
   localparam logic [3:0] KEY_CLEAR = 4'hA;
   localparam logic [3:0] KEY_ENTER = 4'hB;

   typedef enum logic [2:0] {
      IDLE,
      ENTRY,
      COMPARE,
      RESULT,
      DONE
   } state_t;

   state_t state, state_d;

   // Digit registers, nibble i = position i.
   logic [DIGITS-1:0][3:0] secret_q;
   logic [DIGITS-1:0][3:0] guess_q;
   logic [DIGITS-1:0][3:0] secret_nib;

   logic [3:0] entry_count_q;
   logic [3:0] cmp_idx_q;
   logic [3:0] s_acc_q;
   logic [3:0] b_acc_q;
   logic [3:0] strike_q;
   logic [3:0] ball_q;
   logic [3:0] tries_q;
   logic       result_valid_q;
   logic       win_q;
   logic       err_q;

   // Decoded conditions.
   logic       secret_ok;
   logic       key_is_digit;
   logic       key_dup;
   logic [3:0] cur_guess;
   logic [3:0] cur_secret;
   logic       cur_strike;
   logic       cur_in_secret;
   logic [3:0] tries_inc;
   logic       win_now;

   // Control strobes from the FSM to the datapath.
   logic do_load;
   logic do_reject;
   logic do_store;
   logic do_clear;
   logic do_key_err;
   logic do_start;
   logic do_step;
   logic do_result;

   assign secret_nib   = bus.secret_in;
   assign key_is_digit = (bus.key_code <= 4'd9);
   assign tries_inc    = (tries_q == 4'hF) ? 4'hF : tries_q + 4'd1;
   assign win_now      = (s_acc_q == DIGITS_W);

   // A secret is playable only if every nibble is a decimal digit and no
   // digit repeats.
   always_comb begin
      secret_ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (secret_nib[i] > 4'd9) secret_ok = 1'b0;
         for (int k = i + 1; k < DIGITS; k++) begin
            if (secret_nib[i] == secret_nib[k]) secret_ok = 1'b0;
         end
      end
   end

   // Only positions already entered count as duplicates; stale nibbles past
   // entry_count are don't-care.
   always_comb begin
      key_dup = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if ((4'(i) < entry_count_q) && (guess_q[i] == bus.key_code)) key_dup = 1'b1;
      end
   end

   // Digit under comparison this COMPARE cycle, and whether it appears
   // anywhere in the secret (a ball unless it is also a strike).
   always_comb begin
      cur_guess     = '0;
      cur_secret    = '0;
      cur_in_secret = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (4'(i) == cmp_idx_q) begin
            cur_guess  = guess_q[i];
            cur_secret = secret_q[i];
         end
      end
      for (int i = 0; i < DIGITS; i++) begin
         if (secret_q[i] == cur_guess) cur_in_secret = 1'b1;
      end
   end

   assign cur_strike = (cur_guess == cur_secret);

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   // -------------------------------------------------------------------------
   // FSM: next state and datapath strobes
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves one unassigned, which would infer a latch.
      state_d    = state;
      do_load    = 1'b0;
      do_reject  = 1'b0;
      do_store   = 1'b0;
      do_clear   = 1'b0;
      do_key_err = 1'b0;
      do_start   = 1'b0;
      do_step    = 1'b0;
      do_result  = 1'b0;

      if (bus.secret_load) begin
         // A new secret pre-empts whatever is in flight, including a scoring
         // pass, and masks any key presented in the same cycle.
         if (secret_ok) begin
            do_load = 1'b1;
            state_d = ENTRY;
         end else begin
            do_reject = 1'b1;
            state_d   = IDLE;
         end
      end else begin
         case (state)
            IDLE: ;
            ENTRY: begin
               if (bus.key_valid) begin
                  if (key_is_digit) begin
                     if ((entry_count_q < DIGITS_W) && !key_dup) do_store   = 1'b1;
                     else                                       do_key_err = 1'b1;
                  end else if (bus.key_code == KEY_CLEAR) begin
                     do_clear = 1'b1;
                  end else if (bus.key_code == KEY_ENTER) begin
                     if (entry_count_q == DIGITS_W) begin
                        do_start = 1'b1;
                        state_d  = COMPARE;
                     end else begin
                        do_key_err = 1'b1;
                     end
                  end
               end
            end
            COMPARE: begin
               do_step = 1'b1;
               if (cmp_idx_q == LAST_IDX) state_d = RESULT;
            end
            RESULT: begin
               do_result = 1'b1;
               if (win_now || (tries_inc == MAX_W)) state_d = DONE;
               else                                 state_d = ENTRY;
            end
            DONE: ;
            default: state_d = IDLE;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Datapath
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the digit arrays are a handful of flops, not a RAM, so they
         // are reset like the rest of the state and a partial guess cannot
         // survive a reset.
         secret_q       <= '0;
         guess_q        <= '0;
         entry_count_q  <= '0;
         cmp_idx_q      <= '0;
         s_acc_q        <= '0;
         b_acc_q        <= '0;
         strike_q       <= '0;
         ball_q         <= '0;
         tries_q        <= '0;
         result_valid_q <= 1'b0;
         win_q          <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register here
         // samples the pre-edge values regardless of statement order.
         result_valid_q <= 1'b0;
         err_q          <= 1'b0;

         if (do_load || do_reject) begin
            // Both outcomes clear the game outputs; only a good secret is kept.
            if (do_load) secret_q <= secret_nib;
            err_q         <= do_reject;
            guess_q       <= '0;
            entry_count_q <= '0;
            cmp_idx_q     <= '0;
            s_acc_q       <= '0;
            b_acc_q       <= '0;
            strike_q      <= '0;
            ball_q        <= '0;
            tries_q       <= '0;
            win_q         <= 1'b0;
         end else if (do_store) begin
            for (int i = 0; i < DIGITS; i++) begin
               if (4'(i) == entry_count_q) guess_q[i] <= bus.key_code;
            end
            entry_count_q <= entry_count_q + 4'd1;
         end else if (do_clear) begin
            guess_q       <= '0;
            entry_count_q <= '0;
         end else if (do_key_err) begin
            err_q <= 1'b1;
         end else if (do_start) begin
            cmp_idx_q <= '0;
            s_acc_q   <= '0;
            b_acc_q   <= '0;
         end else if (do_step) begin
            cmp_idx_q <= cmp_idx_q + 4'd1;
            if (cur_strike)         s_acc_q <= s_acc_q + 4'd1;
            else if (cur_in_secret) b_acc_q <= b_acc_q + 4'd1;
         end else if (do_result) begin
            strike_q       <= s_acc_q;
            ball_q         <= b_acc_q;
            result_valid_q <= 1'b1;
            tries_q        <= tries_inc;
            entry_count_q  <= '0;
            guess_q        <= '0;
            win_q          <= win_now;
         end
      end
   end

   assign bus.strike       = strike_q;
   assign bus.ball         = ball_q;
   assign bus.result_valid = result_valid_q;
   assign bus.entry_count  = entry_count_q;
   assign bus.tries        = tries_q;
   assign bus.win          = win_q;
   assign bus.game_over    = (state == DONE);
   assign bus.err          = err_q;

endmodule

// File: tb/tb_bulls_cows_judge.sv
// ---------------------------------------------------------------------------
// tb_bulls_cows_judge
//  Self-checking bench for bulls_cows_judge (DIGITS=4, MAX_TRIES=2).
//  A game-level model (secret as an int array, guess as a queue, score from
//  digit counting) predicts every output after every key or secret load.
// ---------------------------------------------------------------------------
module tb_bulls_cows_judge;

   localparam int DIGITS    = 4;
   localparam int MAX_TRIES = 2;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   bulls_cows_judge_if #(.DIGITS(DIGITS)) bus ();

   bulls_cows_judge #(
      .DIGITS    (DIGITS),
      .MAX_TRIES (MAX_TRIES)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // Reference model of the game.
   int m_secret [DIGITS];
   int m_guess  [$];
   int m_tries;
   int m_strike;
   int m_ball;
   bit m_win;
   bit m_over;
   bit m_playing;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_guess.delete();
      m_tries   = 0;
      m_strike  = 0;
      m_ball    = 0;
      m_win     = 1'b0;
      m_over    = 1'b0;
      m_playing = 1'b0;
   endtask

   task automatic check_all(input string tag, input bit exp_err, input bit exp_rv);
      check({tag, ".err"},          bus.err,          exp_err);
      check({tag, ".result_valid"}, bus.result_valid, exp_rv);
      check({tag, ".entry_count"},  bus.entry_count,  m_guess.size());
      check({tag, ".tries"},        bus.tries,        m_tries);
      check({tag, ".strike"},       bus.strike,       m_strike);
      check({tag, ".ball"},         bus.ball,         m_ball);
      check({tag, ".win"},          bus.win,          m_win);
      check({tag, ".game_over"},    bus.game_over,    m_over);
   endtask

   // Apply one key to the model: predicted err, and whether Enter starts scoring.
   task automatic model_key(input logic [3:0] code, output bit exp_err, output bit enter);
      bit dup;
      exp_err = 1'b0;
      enter   = 1'b0;
      if (m_playing) begin
         if (code <= 4'd9) begin
            dup = 1'b0;
            foreach (m_guess[i]) if (m_guess[i] == int'(code)) dup = 1'b1;
            if (dup || m_guess.size() >= DIGITS) exp_err = 1'b1;
            else                                 m_guess.push_back(int'(code));
         end else if (code == 4'hA) begin
            m_guess.delete();
         end else if (code == 4'hB) begin
            if (m_guess.size() == DIGITS) enter = 1'b1;
            else                          exp_err = 1'b1;
         end
      end
   endtask

   // Score: strikes by position, balls = shared digits minus strikes.
   task automatic model_score();
      int common;
      m_strike = 0;
      common   = 0;
      for (int i = 0; i < DIGITS; i++) begin
         if (m_guess[i] == m_secret[i]) m_strike++;
         for (int k = 0; k < DIGITS; k++) if (m_guess[i] == m_secret[k]) common++;
      end
      m_ball = common - m_strike;
      m_tries = (m_tries < 15) ? m_tries + 1 : 15;
      m_guess.delete();
      if (m_strike == DIGITS) m_win = 1'b1;
      if (m_win || m_tries == MAX_TRIES) begin
         m_over    = 1'b1;
         m_playing = 1'b0;
      end
   endtask

   // The Enter edge has just happened: outputs hold for DIGITS cycles, then
   // the score appears together with the result_valid pulse.
   task automatic finish_enter(input string tag);
      for (int k = 0; k < DIGITS; k++) begin
         tick();
         check_all({tag, ".busy"}, 1'b0, 1'b0);
      end
      model_score();
      tick();
      check_all({tag, ".scored"}, 1'b0, 1'b1);
   endtask

   task automatic press(input logic [3:0] code, input string tag);
      bit e;
      bit ent;
      model_key(code, e, ent);
      bus.key_valid = 1'b1;
      bus.key_code  = code;
      tick();
      bus.key_valid = 1'b0;
      check_all(tag, e, 1'b0);
      if (ent) finish_enter(tag);
   endtask

   task automatic load_secret(input logic [4*DIGITS-1:0] s, input bit with_key,
                              input logic [3:0] code, input string tag);
      bit       ok;
      bit [9:0] seen;
      int       d;
      ok   = 1'b1;
      seen = '0;
      for (int i = 0; i < DIGITS; i++) begin
         d = int'(s[4*i +: 4]);
         if (d > 9)         ok = 1'b0;
         else if (seen[d])  ok = 1'b0;
         else               seen[d] = 1'b1;
      end
      bus.secret_load = 1'b1;
      bus.secret_in   = s;
      bus.key_valid   = with_key;
      bus.key_code    = code;
      tick();
      bus.secret_load = 1'b0;
      bus.key_valid   = 1'b0;
      model_reset();
      if (ok) begin
         for (int i = 0; i < DIGITS; i++) m_secret[i] = int'(s[4*i +: 4]);
         m_playing = 1'b1;
      end
      check_all(tag, !ok, 1'b0);
   endtask

   function automatic logic [4*DIGITS-1:0] random_secret();
      int                  pool [$];
      int                  idx;
      logic [4*DIGITS-1:0] s;
      for (int v = 0; v < 10; v++) pool.push_back(v);
      s = '0;
      for (int i = 0; i < DIGITS; i++) begin
         idx = int'($urandom_range(0, pool.size() - 1));
         s[4*i +: 4] = 4'(pool[idx]);
         pool.delete(idx);
      end
      return s;
   endfunction

   initial begin
      bit e;
      bit ent;
      int r;
      logic [3:0] code;

      rst             = 1'b1;
      bus.secret_load = 1'b0;
      bus.secret_in   = '0;
      bus.key_valid   = 1'b0;
      bus.key_code    = '0;
      model_reset();
      tick();
      tick();
      check_all("reset", 1'b0, 1'b0);
      rst = 1'b0;
      tick();

      // Keys before any secret are ignored.
      press(4'd3, "idle_key");

      // T1: secret 1234, guess 1243 -> 2 strikes, 2 balls.
      load_secret(16'h4321, 1'b0, 4'h0, "t1_load");
      press(4'd1, "t1_k1");
      press(4'd2, "t1_k2");
      press(4'd4, "t1_k4");
      press(4'd3, "t1_k3");
      press(4'hB, "t1_enter");
      check("t1.strike", bus.strike, 2);
      check("t1.ball",   bus.ball,   2);
      check("t1.tries",  bus.tries,  1);

      // T2: exact guess wins; later keys ignored.
      press(4'd1, "t2_k1");
      press(4'd2, "t2_k2");
      press(4'd3, "t2_k3");
      press(4'd4, "t2_k4");
      press(4'hB, "t2_enter");
      check("t2.win",       bus.win,       1);
      check("t2.game_over", bus.game_over, 1);
      press(4'd5, "t2_after");
      press(4'hB, "t2_after_enter");

      // T3: duplicate digit and short Enter rejected; clear and ignored codes.
      load_secret(16'h8765, 1'b0, 4'h0, "t3_load");
      press(4'd1, "t3_k1");
      press(4'd1, "t3_dup");
      check("t3.dup_err", bus.err, 1);
      press(4'd2, "t3_k2");
      press(4'hB, "t3_short_enter");
      press(4'hD, "t3_ignored");
      press(4'hA, "t3_clear");
      press(4'd1, "t3_k1_again");

      // T4: bad secrets rejected, then digit keys ignored.
      load_secret(16'h1123, 1'b0, 4'h0, "t4_dup_secret");
      check("t4.err", bus.err, 1);
      press(4'd7, "t4_key");
      load_secret(16'hA123, 1'b0, 4'h0, "t4_nondigit");

      // T5: two misses with MAX_TRIES=2 end the game without a win.
      load_secret(16'h4321, 1'b0, 4'h0, "t5_load");
      for (int g = 0; g < 2; g++) begin
         press(4'd9, "t5_k9");
         press(4'd0, "t5_k0");
         press(4'd8, "t5_k8");
         press(4'd7, "t5_k7");
         press(4'hB, "t5_enter");
      end
      check("t5.game_over", bus.game_over, 1);
      check("t5.win",       bus.win,       0);
      check("t5.tries",     bus.tries,     2);

      // Fifth digit when full is rejected.
      load_secret(16'h4321, 1'b0, 4'h0, "full_load");
      press(4'd5, "full_k5");
      press(4'd6, "full_k6");
      press(4'd7, "full_k7");
      press(4'd8, "full_k8");
      press(4'd9, "full_k9");

      // T6: new secret during COMPARE aborts the scoring pass.
      model_key(4'hB, e, ent);
      bus.key_valid = 1'b1;
      bus.key_code  = 4'hB;
      tick();
      bus.key_valid = 1'b0;
      tick();
      tick();
      load_secret(16'h2109, 1'b0, 4'h0, "t6_load");
      for (int k = 0; k < DIGITS + 2; k++) check_all("t6_quiet", 1'b0, 1'b0);
      for (int k = 0; k < DIGITS + 2; k++) begin
         tick();
         check_all("t6_quiet", 1'b0, 1'b0);
      end
      press(4'd0, "t6_entry");

      // secret_load wins over a simultaneous key.
      load_secret(16'h8765, 1'b1, 4'd5, "prio_load");
      press(4'd5, "prio_k5");

      // Asynchronous reset mid-entry discards the partial guess.
      press(4'd6, "mid_k6");
      rst = 1'b1;
      #2;
      model_reset();
      check_all("mid_reset", 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      tick();
      press(4'd1, "post_reset_key");

      // Randomized games.
      for (int g = 0; g < 40; g++) begin
         if ($urandom_range(0, 7) == 0) load_secret(16'($urandom), 1'b0, 4'h0, "rnd_load_raw");
         else                           load_secret(random_secret(), 1'b0, 4'h0, "rnd_load");
         for (int k = 0; k < 30; k++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 5)      code = 4'($urandom_range(0, 9));
            else if (r == 6) code = 4'hA;
            else if (r <= 8) code = 4'hB;
            else             code = 4'($urandom_range(12, 15));
            press(code, "rnd_key");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
